// File: rtl/pay_accum.sv
// Payment stage for the vending controller: prices the selected item, accumulates
// coins, and issues the vend strobe with change, or a full refund on cancel or timeout.
module pay_accum #(
  parameter int unsigned P_LOW       = 3,
  parameter int unsigned P_MID       = 5,
  parameter int unsigned P_HIGH      = 8,
  parameter int unsigned MAX_PAID    = 100,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] area_flag,
  input  logic [3:0] goods_index,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  output logic       enough_flag,
  output logic [7:0] price,
  output logic [7:0] paid,
  output logic       coin_reject,
  output logic       dispense,
  output logic [3:0] dispense_index,
  output logic       change_valid,
  output logic [7:0] change
);

  localparam int unsigned     CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]      MAX_SUM     = 9'(MAX_PAID);
  localparam logic [4:0]      KEY_NONE    = 5'd0;
  localparam logic [4:0]      KEY_CONFIRM = 5'd17;
  localparam logic [4:0]      KEY_CANCEL  = 5'd18;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DONE    = 2'd1,
    REFUND  = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       paid_q;
  logic [7:0]       change_q;
  logic [3:0]       dispense_index_q;
  logic             coin_reject_q;
  logic             dispense_q;
  logic             change_valid_q;
  logic [CNT_W-1:0] idle_cnt_q;

  logic [7:0] coin_units;
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic [7:0] paid_in;
  logic       confirm_hit;
  logic       cancel_hit;
  logic       idle_hit;
  logic       timeout_hit;

  function automatic logic [7:0] coin_decode(input logic [1:0] code);
    logic [7:0] units;
    case (code)
      2'b00:   units = 8'd1;
      2'b01:   units = 8'd5;
      2'b10:   units = 8'd10;
      2'b11:   units = 8'd20;
      default: units = 8'd0;
    endcase
    return units;
  endfunction

  // Price decode from the current selection.
  always_comb begin
    price = 8'd0;
    if (goods_index == 4'd0) begin
      price = 8'd0;
    end else if (goods_index <= 4'd4) begin
      price = 8'(P_LOW);
    end else if (goods_index <= 4'd8) begin
      price = 8'(P_MID);
    end else if (goods_index <= 4'd12) begin
      price = 8'(P_HIGH);
    end else begin
      price = 8'd0;
    end
  end

  // paid_in is the accumulator including a coin accepted this cycle; enough_flag uses registered paid only.
  always_comb begin
    coin_units  = coin_decode(coin_value);
    coin_sum    = {1'b0, paid_q} + {1'b0, coin_units};
    coin_ok     = coin_valid && (coin_sum <= MAX_SUM);
    paid_in     = coin_ok ? coin_sum[7:0] : paid_q;
    enough_flag = (goods_index != 4'd0) && (paid_q >= price);
    confirm_hit = (area_flag == KEY_CONFIRM) && enough_flag;
    cancel_hit  = (area_flag == KEY_CANCEL) && (paid_in != 8'd0);
    idle_hit    = (paid_q != 8'd0) && !coin_valid && (area_flag == KEY_NONE);
    timeout_hit = idle_hit && (idle_cnt_q == CNT_LAST);
  end

  // Collect / vend / refund sequencing with registered strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= COLLECT;
      paid_q           <= 8'd0;
      change_q         <= 8'd0;
      dispense_index_q <= 4'd0;
      coin_reject_q    <= 1'b0;
      dispense_q       <= 1'b0;
      change_valid_q   <= 1'b0;
      idle_cnt_q       <= '0;
    end else begin
      coin_reject_q  <= coin_valid && !coin_ok;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (confirm_hit) begin
            state_q          <= DONE;
            dispense_q       <= 1'b1;
            change_valid_q   <= 1'b1;
            dispense_index_q <= goods_index;
            change_q         <= paid_in - price;
            paid_q           <= 8'd0;
            idle_cnt_q       <= '0;
          end else if (cancel_hit) begin
            state_q        <= REFUND;
            change_valid_q <= 1'b1;
            change_q       <= paid_in;
            paid_q         <= 8'd0;
            idle_cnt_q     <= '0;
          end else if (timeout_hit) begin
            state_q        <= REFUND;
            change_valid_q <= 1'b1;
            change_q       <= paid_q;
            paid_q         <= 8'd0;
            idle_cnt_q     <= '0;
          end else begin
            paid_q     <= paid_in;
            idle_cnt_q <= idle_hit ? (idle_cnt_q + CNT_W'(1)) : '0;
          end
        end
        // Strobe cycle: keys are ignored, coins accumulate from zero.
        DONE, REFUND: begin
          state_q    <= COLLECT;
          paid_q     <= paid_in;
          idle_cnt_q <= '0;
        end
        default: begin
          state_q    <= COLLECT;
          paid_q     <= 8'd0;
          idle_cnt_q <= '0;
        end
      endcase
    end
  end

  assign paid           = paid_q;
  assign change         = change_q;
  assign dispense_index = dispense_index_q;
  assign coin_reject    = coin_reject_q;
  assign dispense       = dispense_q;
  assign change_valid   = change_valid_q;

endmodule

// File: tb/tb_pay_accum.sv
// Self-checking bench for pay_accum: directed vector table, timeout and reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_pay_accum;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] area_flag;
  logic [3:0] goods_index;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       enough_flag;
  logic [7:0] price;
  logic [7:0] paid;
  logic       coin_reject;
  logic       dispense;
  logic [3:0] dispense_index;
  logic       change_valid;
  logic [7:0] change;

  int tests = 0;
  int fails = 0;

  pay_accum #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .area_flag      (area_flag),
    .goods_index    (goods_index),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .enough_flag    (enough_flag),
    .price          (price),
    .paid           (paid),
    .coin_reject    (coin_reject),
    .dispense       (dispense),
    .dispense_index (dispense_index),
    .change_valid   (change_valid),
    .change         (change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] area;
    logic [3:0] goods;
    logic       cv;
    logic [1:0] cval;
    logic [7:0] e_paid;
    logic       e_cvld;
    logic       e_disp;
    logic [7:0] e_chg;
    logic [3:0] e_didx;
    logic       e_rej;
    logic       e_en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int area, input int goods, input int cv, input int cval,
                     input int e_paid, input int e_cvld, input int e_disp, input int e_chg,
                     input int e_didx, input int e_rej, input int e_en);
    vec_t v;
    v.area = 5'(area);   v.goods = 4'(goods); v.cv = 1'(cv);   v.cval = 2'(cval);
    v.e_paid = 8'(e_paid); v.e_cvld = 1'(e_cvld); v.e_disp = 1'(e_disp);
    v.e_chg = 8'(e_chg); v.e_didx = 4'(e_didx); v.e_rej = 1'(e_rej); v.e_en = 1'(e_en);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-unit amounts and a count of consecutive idle cycles.
  int m_paid, m_change, m_didx, m_idle;
  bit m_busy, m_cvld, m_disp, m_rej;
  int coin_units[4] = '{1, 5, 10, 20};

  function automatic int price_of(input int g);
    if (g >= 1 && g <= 4)  return 3;
    if (g >= 5 && g <= 8)  return 5;
    if (g >= 9 && g <= 12) return 8;
    return 0;
  endfunction

  task automatic model_reset();
    m_paid = 0; m_change = 0; m_didx = 0; m_idle = 0;
    m_busy = 0; m_cvld = 0; m_disp = 0; m_rej = 0;
  endtask

  task automatic model_step();
    int  val, total, pr;
    bit  ok, enough;
    val    = coin_units[coin_value];
    ok     = coin_valid && (m_paid + val <= 100);
    total  = ok ? m_paid + val : m_paid;
    pr     = price_of(int'(goods_index));
    enough = (goods_index != 0) && (m_paid >= pr);
    m_rej  = coin_valid && !ok;
    m_cvld = 0;
    m_disp = 0;
    if (m_busy) begin
      m_busy = 0; m_paid = total; m_idle = 0;
    end else if (area_flag == 17 && enough) begin
      m_disp = 1; m_cvld = 1; m_didx = int'(goods_index);
      m_change = total - pr; m_paid = 0; m_busy = 1; m_idle = 0;
    end else if (area_flag == 18 && (m_paid != 0 || ok)) begin
      m_cvld = 1; m_change = total; m_paid = 0; m_busy = 1; m_idle = 0;
    end else if (m_paid != 0 && !coin_valid && area_flag == 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_cvld = 1; m_change = m_paid; m_paid = 0; m_busy = 1; m_idle = 0;
      end
    end else begin
      m_paid = total; m_idle = 0;
    end
  endtask

  task automatic drive(input int area, input int goods, input int cv, input int cval);
    area_flag = 5'(area); goods_index = 4'(goods); coin_valid = 1'(cv); coin_value = 2'(cval);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int quiet;
    rstn = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_paid", paid, 0);
    check("rst_change", change, 0);
    check("rst_didx", dispense_index, 0);
    check("rst_strobes", {coin_reject, dispense, change_valid}, 0);
    check("rst_enough", enough_flag, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Directed table: inputs for one cycle, registered outputs expected after the edge.
    add( 0,  3, 1, 0,   1, 0, 0,  0,  0, 0, 0);
    add( 0,  3, 1, 0,   2, 0, 0,  0,  0, 0, 0);
    add( 0,  3, 1, 0,   3, 0, 0,  0,  0, 0, 1);
    add(17,  3, 0, 0,   0, 1, 1,  0,  3, 0, 0);
    add( 0,  3, 0, 0,   0, 0, 0,  0,  3, 0, 0);
    add( 0, 10, 1, 2,  10, 0, 0,  0,  3, 0, 1);
    add(17, 10, 0, 0,   0, 1, 1,  2, 10, 0, 0);
    add( 0,  7, 1, 0,   1, 0, 0,  2, 10, 0, 0);
    add(17,  7, 0, 0,   1, 0, 0,  2, 10, 0, 0);
    add( 0,  7, 1, 1,   6, 0, 0,  2, 10, 0, 1);
    add(17,  7, 0, 0,   0, 1, 1,  1,  7, 0, 0);
    add( 0,  0, 1, 2,  10, 0, 0,  1,  7, 0, 0);
    add( 0,  0, 1, 1,  15, 0, 0,  1,  7, 0, 0);
    add(18,  0, 0, 0,   0, 1, 0, 15,  7, 0, 0);
    add( 0,  0, 0, 0,   0, 0, 0, 15,  7, 0, 0);
    add(18,  0, 0, 0,   0, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 3,  20, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 3,  40, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 3,  60, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 3,  80, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 2,  90, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 1,  95, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 2,  95, 0, 0, 15,  7, 1, 0);
    add( 0,  0, 1, 1, 100, 0, 0, 15,  7, 0, 0);
    add( 0,  0, 1, 0, 100, 0, 0, 15,  7, 1, 0);
    add(17, 12, 1, 3,   0, 1, 1, 92, 12, 1, 0);
    add(17,  0, 1, 1,   5, 0, 0, 92, 12, 0, 0);
    add(17,  4, 1, 0,   0, 1, 1,  3,  4, 0, 0);
    add(17,  4, 1, 1,   5, 0, 0,  3,  4, 0, 1);
    add(18,  4, 0, 0,   0, 1, 0,  5,  4, 0, 0);
    add(18,  4, 1, 0,   1, 0, 0,  5,  4, 0, 0);
    add(18,  4, 0, 0,   0, 1, 0,  1,  4, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(int'(vecs[i].area), int'(vecs[i].goods), int'(vecs[i].cv), int'(vecs[i].cval));
      tick();
      check($sformatf("v%0d_paid", i), paid, vecs[i].e_paid);
      check($sformatf("v%0d_change_valid", i), change_valid, vecs[i].e_cvld);
      check($sformatf("v%0d_dispense", i), dispense, vecs[i].e_disp);
      check($sformatf("v%0d_change", i), change, vecs[i].e_chg);
      check($sformatf("v%0d_didx", i), dispense_index, vecs[i].e_didx);
      check($sformatf("v%0d_reject", i), coin_reject, vecs[i].e_rej);
      check($sformatf("v%0d_enough", i), enough_flag, vecs[i].e_en);
    end

    // Timeout: a single 5-unit coin then silence refunds exactly TO cycles later.
    drive(0, 0, 1, 1);
    tick();
    check("to_coin_paid", paid, 5);
    drive(0, 0, 0, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (change_valid) begin
        lat = k;
        break;
      end
    end
    check("to_latency", lat, TO);
    check("to_change", change, 5);
    check("to_paid", paid, 0);
    check("to_dispense", dispense, 0);

    // Reset in the middle of collecting discards paid without a refund.
    drive(0, 0, 1, 3);
    tick();
    tick();
    check("mid_paid", paid, 40);
    drive(0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_paid", paid, 0);
    check("mid_rst_change", change, 0);
    check("mid_rst_didx", dispense_index, 0);
    check("mid_rst_strobes", {coin_reject, dispense, change_valid}, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_no_refund", {change_valid, paid}, 0);
    end

    // Randomized traffic against the reference model.
    model_reset();
    quiet = 0;
    goods_index = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (quiet > 0) begin
        area_flag  = 5'd0;
        coin_valid = 1'b0;
        quiet--;
      end else begin
        case ($urandom_range(0, 9))
          0:       area_flag = 5'd17;
          1:       area_flag = 5'd18;
          2:       area_flag = 5'($urandom_range(0, 31));
          default: area_flag = 5'd0;
        endcase
        coin_valid = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 30) == 0) quiet = $urandom_range(4, 12);
      end
      coin_value = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) goods_index = 4'($urandom_range(0, 15));
      #1;
      check("rnd_price", price, price_of(int'(goods_index)));
      check("rnd_enough", enough_flag, (goods_index != 0) && (m_paid >= price_of(int'(goods_index))));
      model_step();
      tick();
      check("rnd_paid", paid, m_paid);
      check("rnd_change_valid", change_valid, m_cvld);
      check("rnd_dispense", dispense, m_disp);
      check("rnd_reject", coin_reject, m_rej);
      check("rnd_change", change, m_change);
      check("rnd_didx", dispense_index, m_didx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
